// File: rtl/usb_pkg.sv
// Shared USB line-level definitions: transmit FSM states and the J/K/SE0 encodings on {d_plus,d_minus}.
package usb_pkg;

  typedef enum logic [1:0] {IDLE, DATA, SE0, EOP_J} tx_line_state_e;

  localparam logic [1:0] USB_SE0  = 2'b00;
  localparam logic [1:0] USB_J_FS = 2'b10;
  localparam logic [1:0] USB_J_LS = 2'b01;

  function automatic logic [1:0] usb_j_level(input bit low_speed);
    return low_speed ? USB_J_LS : USB_J_FS;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Free-running bit-time counter; bit_tick is high on the last clock of each bit time.
// Zero latency on bit_tick; clear restarts the bit time on the following cycle.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] bit_cnt;

  assign bit_tick = (bit_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clear || bit_tick) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_tx_eop_generator.sv
// Serialises pre-encoded line levels onto D+/D- and closes each packet with SE0 then J; outputs registered (1 cycle).
// tx_ready only in IDLE or on the last clock of a data bit; stalls upstream for the whole EOP.
module usb_tx_eop_generator
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int SE0_BITS     = 2,
  parameter int J_BITS       = 1,
  parameter int LOW_SPEED    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_valid,
  input  logic tx_bit,
  output logic tx_ready,
  output logic d_plus,
  output logic d_minus,
  output logic tx_oe,
  output logic tx_busy,
  output logic eop_done
);

  localparam int PH_MAX = (SE0_BITS > J_BITS) ? SE0_BITS : J_BITS;
  localparam int PW     = $clog2(PH_MAX + 1);

  localparam logic [1:0]    J_LVL    = usb_j_level(LOW_SPEED != 0);
  localparam logic [1:0]    K_LVL    = ~J_LVL;
  localparam logic [PW-1:0] SE0_LAST = PW'(SE0_BITS - 1);
  localparam logic [PW-1:0] J_LAST   = PW'(J_BITS - 1);

  tx_line_state_e state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [1:0]     line_q, line_d;
  logic           oe_q, oe_d;
  logic           done_q, done_d;
  logic           bit_tick;
  logic           start_xfer;

  assign tx_ready   = (state_q == IDLE) | ((state_q == DATA) & bit_tick);
  assign start_xfer = (state_q == IDLE) & tx_valid;

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_xfer),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    line_d  = line_q;
    oe_d    = oe_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = DATA;
          oe_d    = 1'b1;
          line_d  = tx_bit ? J_LVL : K_LVL;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (tx_valid) begin
            line_d = tx_bit ? J_LVL : K_LVL;
          end else begin
            state_d = SE0;
            line_d  = USB_SE0;
            phase_d = '0;
          end
        end
      end
      SE0: begin
        if (bit_tick) begin
          if (phase_q == SE0_LAST) begin
            state_d = EOP_J;
            line_d  = J_LVL;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      EOP_J: begin
        if (bit_tick) begin
          if (phase_q == J_LAST) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            done_d  = 1'b1;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      line_q  <= J_LVL;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      line_q  <= line_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

  assign d_plus   = line_q[1];
  assign d_minus  = line_q[0];
  assign tx_oe    = oe_q;
  assign eop_done = done_q;
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_eop_generator.sv
// Directed bench for usb_tx_eop_generator: full-speed and low-speed instances, per-cycle expected-output scoreboard.
module tb_usb_tx_eop_generator;

  typedef struct packed {
    logic       oe;
    logic [1:0] ln;
    logic       done;
    logic       rdy;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic vld_fs = 1'b0, bit_fs = 1'b0;
  logic vld_ls = 1'b0, bit_ls = 1'b0;
  logic rdy_fs, dp_fs, dm_fs, oe_fs, busy_fs, done_fs;
  logic rdy_ls, dp_ls, dm_ls, oe_ls, busy_ls, done_ls;
  obs_t obs_fs, obs_ls;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pkt_no = 0;

  always #5 clk = ~clk;

  usb_tx_eop_generator #(
    .CLKS_PER_BIT(4), .SE0_BITS(2), .J_BITS(1), .LOW_SPEED(0)
  ) dut_fs (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld_fs), .tx_bit(bit_fs), .tx_ready(rdy_fs),
    .d_plus(dp_fs), .d_minus(dm_fs), .tx_oe(oe_fs), .tx_busy(busy_fs), .eop_done(done_fs)
  );

  usb_tx_eop_generator #(
    .CLKS_PER_BIT(4), .SE0_BITS(2), .J_BITS(1), .LOW_SPEED(1)
  ) dut_ls (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld_ls), .tx_bit(bit_ls), .tx_ready(rdy_ls),
    .d_plus(dp_ls), .d_minus(dm_ls), .tx_oe(oe_ls), .tx_busy(busy_ls), .eop_done(done_ls)
  );

  assign obs_fs = {oe_fs, dp_fs, dm_fs, done_fs, rdy_fs, busy_fs};
  assign obs_ls = {oe_ls, dp_ls, dm_ls, done_ls, rdy_ls, busy_ls};

  function automatic obs_t cur_obs(input bit ls);
    return ls ? obs_ls : obs_fs;
  endfunction

  function automatic logic cur_vld(input bit ls);
    return ls ? vld_ls : vld_fs;
  endfunction

  function automatic logic [1:0] j_of(input bit ls);
    return ls ? 2'b01 : 2'b10;
  endfunction

  function automatic obs_t mk(input logic oe, input logic [1:0] ln, input logic done,
                              input logic rdy, input logic busy);
    obs_t r;
    r.oe = oe; r.ln = ln; r.done = done; r.rdy = rdy; r.busy = busy;
    return r;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed{oe,dp,dm,done,rdy,busy}=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit ls, input logic v, input logic b);
    if (ls) begin
      vld_ls = v; bit_ls = b;
    end else begin
      vld_fs = v; bit_fs = b;
    end
  endtask

  // Called at a negedge with the DUT idle. Records j = cycle index after the accepting edge.
  task automatic send_pkt(input logic [15:0] bits, input int n, input bit ls,
                          input int drop_lo, input int drop_hi);
    obs_t       e, got;
    logic [1:0] jl;
    int         idx, j, oe_cycles;
    bit         fire, drop;
    jl = j_of(ls);
    pkt_no++;
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(mk(1'b1, bits[i] ? jl : ~jl, 1'b0, c == 3, 1'b1));
    for (int c = 0; c < 8; c++) exp_q.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1));
    for (int c = 0; c < 4; c++) exp_q.push_back(mk(1'b1, jl, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, jl, 1'b1, 1'b1, 1'b0));
    idx = 0; j = -1; oe_cycles = 0;
    while (exp_q.size() > 0) begin
      drop = (j >= drop_lo) && (j <= drop_hi);
      if (idx < n && !drop) drive(ls, 1'b1, bits[idx]);
      else                  drive(ls, 1'b0, 1'($urandom_range(1, 0)));
      #1;
      fire = cur_vld(ls) && cur_obs(ls).rdy;
      @(posedge clk);
      if (fire) idx++;
      @(negedge clk);
      j++;
      got = cur_obs(ls);
      e = exp_q.pop_front();
      check($sformatf("pkt%0d_cyc%0d", pkt_no, j), got, e);
      if (got.oe) oe_cycles++;
    end
    check_int($sformatf("pkt%0d_oe_cycles", pkt_no), oe_cycles, (n + 3) * 4);
  endtask

  task automatic idle_cycles(input int n, input bit ls);
    for (int i = 0; i < n; i++) begin
      drive(ls, 1'b0, 1'($urandom_range(1, 0)));
      exp_q.push_back(mk(1'b0, j_of(ls), 1'b0, 1'b1, 1'b0));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("idle_ls%0d_%0d", ls, i), cur_obs(ls), exp_q.pop_front());
    end
  endtask

  initial begin
    // Reset state, both line-speed encodings
    @(negedge clk);
    check("reset_fs", obs_fs, mk(1'b0, 2'b10, 1'b0, 1'b1, 1'b0));
    check("reset_ls", obs_ls, mk(1'b0, 2'b01, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;
    idle_cycles(2, 1'b0);
    idle_cycles(1, 1'b1);

    // 8-bit packet 1,0,0,1,1,1,0,1 (first bit in bits[0])
    send_pkt(16'h00B9, 8, 1'b0, -10, -10);
    idle_cycles(3, 1'b0);

    // tx_valid dropped mid-bit in bits 0 and 1; must not truncate or end the packet
    send_pkt(16'h0005, 3, 1'b0, 1, 2);
    idle_cycles(1, 1'b0);
    send_pkt(16'h0002, 2, 1'b0, 5, 6);
    idle_cycles(2, 1'b0);

    // Single K bit
    send_pkt(16'h0000, 1, 1'b0, -10, -10);
    idle_cycles(2, 1'b0);

    // Back-to-back: second packet accepted on the eop_done cycle
    send_pkt(16'h0001, 2, 1'b0, -10, -10);
    send_pkt(16'h0006, 3, 1'b0, -10, -10);
    idle_cycles(2, 1'b0);

    // Low speed: J=01, K=10
    send_pkt(16'h000D, 4, 1'b1, -10, -10);
    idle_cycles(2, 1'b1);

    // Async reset mid-DATA: immediate release of the bus, no EOP
    drive(1'b0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    check("pre_reset_busy", obs_fs, mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b0;
    #1;
    check("async_reset_fs", obs_fs, mk(1'b0, 2'b10, 1'b0, 1'b1, 1'b0));
    check("async_reset_ls", obs_ls, mk(1'b0, 2'b01, 1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("reset_held_fs", obs_fs, mk(1'b0, 2'b10, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;
    idle_cycles(3, 1'b0);
    send_pkt(16'h0003, 2, 1'b0, -10, -10);
    idle_cycles(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
